fifo_rd_streamer: RTL and testbench
===================================

// Module: fifo_rd_streamer
// PURPOSE
//  Read-side consumer for the 16-bit async FIFO. Lives in the rd_clk domain.
//  - Drains the FIFO's show-ahead read port: fifo_rd_data is valid while fifo_empty=0.
//  - Re-presents the words as a valid/ready stream through a 2-entry skid buffer.
//  - Marks packet boundaries: out_last on every PKT_LEN-th word.
// PARAMETERS
//  DATA_W   16  word width; must match the FIFO data width
//  PKT_LEN  8   words per packet, 1..255
//  IDX_W    8   width of the packet word index; 2**IDX_W >= PKT_LEN
// PORTS
//  rd_clk        in   1       clock, same as the FIFO read clock
//  rd_rst        in   1       synchronous reset, active-high
//  fifo_rd_data  in   DATA_W  FIFO head word; valid while fifo_empty=0
//  fifo_empty    in   1       FIFO empty flag
//  fifo_rd_en    out  1       pop request to the FIFO
//  out_data      out  DATA_W  stream data
//  out_valid     out  1       stream valid
//  out_ready     in   1       stream ready from the downstream sink
//  out_last      out  1       qualifies out_data as the final word of a packet
//  pkt_done      out  1       1-cycle pulse when a last word is accepted
// BEHAVIOUR
//  - Single clock. All state updates on posedge rd_clk.
//  - rd_rst is synchronous and active-high.
//  - Reset values:
//    - cnt=0, idx=0, buffer entries=0.
//    - out_valid=0, out_last=0, pkt_done=0, out_data=0.
//  - fifo_rd_en = !rd_rst && !fifo_empty && (cnt != 2).
//    - Combinational from registered state only; no path from out_ready.
//  - Pop: when fifo_rd_en=1, fifo_rd_data is written into the buffer at the same edge.
//    - The word is visible on out_data the next cycle at the earliest (1-cycle latency).
//  - Buffer FSM, keyed on occupancy cnt:
//    - EMPTY(0): on push -> ONE.
//    - ONE(1):
//      - push & !accept -> TWO
//      - accept & !push -> EMPTY
//      - push & accept  -> ONE
//      - neither        -> ONE
//    - TWO(2): push is impossible.
//      - accept -> ONE, else stay in TWO.
//  - accept = out_valid && out_ready.
//  - out_valid = (cnt != 0). out_data is always the oldest entry (head).
//  - Hold rule: while out_valid=1 && out_ready=0, out_data and out_last stay stable.
//  - Steady state with out_ready=1 and a non-empty FIFO: one word per cycle.
//  - Packet index idx counts accepted words, 0..PKT_LEN-1.
//    - out_last = out_valid && (idx == PKT_LEN-1).
//    - On accept: if idx == PKT_LEN-1 then idx <= 0 and pkt_done pulses next cycle;
//      otherwise idx <= idx+1.
//  - PKT_LEN=1: out_last=1 on every valid word.
//  - FIFO empty mid-packet: out_valid drops, idx is held. The packet resumes later, no reset of idx.
//  - Simultaneous push and accept at cnt=1: head advances to the just-pushed word; cnt stays 1.
//  - Reset mid-operation:
//    - Buffered words are discarded and idx=0.
//    - No pop occurs while rd_rst=1.
//    - FIFO contents are untouched; the FIFO's own rd_rst_n governs them.
// CONFIGURATION
//  RD_STREAMER_STATS_EN
//  - Defined: adds outputs words_sent[15:0] and stall_cycles[15:0], both reset to 0.
//    - words_sent increments on each accept.
//    - stall_cycles increments on each cycle with out_valid && !out_ready.
//    - Both saturate at 16'hFFFF.
//  - Undefined: those ports and counters do not exist. All other behaviour is identical.
// TESTING
//  1. Reset: hold rd_rst=1 for 3 cycles with fifo_empty=0.
//     -> fifo_rd_en=0, out_valid=0, out_last=0, pkt_done=0 throughout.
//  2. Streaming: FIFO holds 0x0001..0x0010, out_ready=1, PKT_LEN=8.
//     -> 16 words in order at 1 word/cycle after 1-cycle latency.
//     -> out_last on 0x0008 and 0x0010; pkt_done pulses twice.
//  3. Backpressure: out_ready=0 with 5 words in the FIFO.
//     -> cnt reaches 2 and fifo_rd_en drops. out_data holds 0x0001.
//     -> Releasing out_ready delivers 0x0001..0x0005 with no loss or duplicates.
//  4. Underrun: FIFO goes empty after word 3 of a packet, refills 5 cycles later.
//     -> out_valid=0 during the gap.
//     -> out_last on the 5th word after refill (the 8th word of the packet).
//  5. Reset mid-packet: assert rd_rst with cnt=2 and idx=5.
//     -> Next cycle: out_valid=0, idx=0. The next word accepted is idx 0.
//  6. With RD_STREAMER_STATS_EN, run 10 accepts and 4 stall cycles.
//     -> words_sent=10, stall_cycles=4.

Source files
------------

// File: rtl/fifo_rd_streamer.sv
// ---------------------------------------------------------------------------
// fifo_rd_streamer
//
// Read-side consumer for a show-ahead async FIFO, living in the rd_clk domain.
// Pops words from the FIFO head and re-presents them as a valid/ready stream
// through a 2-entry skid buffer. out_last marks every PKT_LEN-th accepted
// word, and pkt_done pulses for one cycle after such a word is accepted.
//
// Optional feature macro: RD_STREAMER_STATS_EN
//   When defined, adds the saturating counters words_sent and stall_cycles.
//
// Ports
//   rd_clk        in   1       clock, same as the FIFO read clock
//   rd_rst        in   1       synchronous reset, active-high
//   fifo_rd_data  in   DATA_W  FIFO head word, valid while fifo_empty=0
//   fifo_empty    in   1       FIFO empty flag
//   fifo_rd_en    out  1       pop request to the FIFO
//   out_data      out  DATA_W  stream data (oldest buffered word)
//   out_valid     out  1       stream valid
//   out_ready     in   1       stream ready from the downstream sink
//   out_last      out  1       out_data is the final word of a packet
//   pkt_done      out  1       1-cycle pulse after a last word is accepted
//   words_sent    out  16      accepted-word count   (RD_STREAMER_STATS_EN)
//   stall_cycles  out  16      valid-but-not-ready cycles (RD_STREAMER_STATS_EN)
// ---------------------------------------------------------------------------
module fifo_rd_streamer #(
  parameter int DATA_W  = 16,
  parameter int PKT_LEN = 8,
  parameter int IDX_W   = 8
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              pkt_done
`ifdef RD_STREAMER_STATS_EN
  ,
  output logic [15:0]       words_sent,
  output logic [15:0]       stall_cycles
`endif
);

  // Buffer occupancy doubles as the FSM state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  occ_e              cnt_q, cnt_d;
  logic [DATA_W-1:0] head_q, head_d;   // oldest entry, drives out_data
  logic [DATA_W-1:0] tail_q, tail_d;   // second entry, only meaningful in TWO
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;

  logic push;
  logic accept;
  logic at_last;

  // Pop decision depends on registered occupancy only, so there is no
  // combinational path from out_ready back to the FIFO.
  assign fifo_rd_en = !rd_rst && !fifo_empty && (cnt_q != TWO);
  assign push       = fifo_rd_en;

  assign out_valid  = (cnt_q != EMPTY);
  assign out_data   = head_q;
  assign at_last    = (idx_q == LAST_IDX);
  assign out_last   = out_valid && at_last;
  assign pkt_done   = done_q;
  assign accept     = out_valid && out_ready;

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred; blocking '=' is correct
  // in combinational logic.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case (cnt_q)
      EMPTY: begin
        if (push) begin
          head_d = fifo_rd_data;
          cnt_d  = ONE;
        end
      end
      ONE: begin
        case ({push, accept})
          2'b10: begin
            tail_d = fifo_rd_data;
            cnt_d  = TWO;
          end
          2'b01: cnt_d = EMPTY;
          // Head is consumed and replaced by the word popped this cycle.
          2'b11: head_d = fifo_rd_data;
          default: ;
        endcase
      end
      TWO: begin
        // No push possible here: fifo_rd_en is forced low when full.
        if (accept) begin
          head_d = tail_q;
          cnt_d  = ONE;
        end
      end
      default: cnt_d = EMPTY;
    endcase
  end

  // Packet index advances only on accepted words, so an underrun simply
  // pauses the packet rather than restarting it.
  always_comb begin
    idx_d  = idx_q;
    done_d = 1'b0;
    if (accept) begin
      if (at_last) begin
        idx_d  = '0;
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

`ifdef RD_STREAMER_STATS_EN
  logic [15:0] words_q;
  logic [15:0] stall_q;
  assign words_sent   = words_q;
  assign stall_cycles = stall_q;
`endif

  // NOTE: state updates use non-blocking '<=' so every register samples the
  // pre-edge values. The two buffer entries are reset along with the control
  // state so out_data reads 0 after reset instead of stale or X data.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      cnt_q   <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef RD_STREAMER_STATS_EN
      words_q <= '0;
      stall_q <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef RD_STREAMER_STATS_EN
      // Both counters saturate at all-ones.
      if (accept && (words_q != 16'hFFFF)) begin
        words_q <= words_q + 16'd1;
      end
      if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_streamer
//
// Self-checking bench for fifo_rd_streamer. A queue stands in for the FIFO;
// a queue-based reference model (buffered words, packet index, pending
// pkt_done) predicts the stream cycle by cycle. Inputs change on the falling
// edge and outputs are sampled 1 time unit later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_fifo_rd_streamer;

  localparam int DATA_W  = 16;
  localparam int PKT_LEN = 8;
  localparam int IDX_W   = 8;

  logic              rd_clk = 1'b0;
  logic              rd_rst;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              pkt_done;
`ifdef RD_STREAMER_STATS_EN
  logic [15:0]       words_sent;
  logic [15:0]       stall_cycles;
`endif

  always #5 rd_clk = ~rd_clk;

  fifo_rd_streamer #(
    .DATA_W (DATA_W),
    .PKT_LEN(PKT_LEN),
    .IDX_W  (IDX_W)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .pkt_done    (pkt_done)
`ifdef RD_STREAMER_STATS_EN
    ,
    .words_sent  (words_sent),
    .stall_cycles(stall_cycles)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] fq[$];     // FIFO contents, head at index 0
  logic [15:0] bq[$];     // model: words held by the streamer, oldest first
  int          m_idx;     // model: packet index of the head word
  bit          m_done;    // model: pkt_done expected this cycle
  int          m_ws;      // model: words_sent
  int          m_sc;      // model: stall_cycles

  logic [15:0] acc[$];    // words the DUT handed over on accept
  logic [15:0] lasts[$];  // accepted words the DUT flagged with out_last
  int          n_done;    // pkt_done pulses seen

  logic        obs_rd_en;
  logic        obs_valid;
  logic        obs_last;
  logic        obs_done;
  logic [15:0] obs_data;

  // One clock cycle: drive inputs, compare DUT to model, advance both.
  task automatic cycle(input bit rst, input bit rdy);
    bit e_valid, e_rd_en, e_last, acc_now;
    @(negedge rd_clk);
    rd_rst       = rst;
    out_ready    = rdy;
    fifo_empty   = (fq.size() == 0);
    fifo_rd_data = fifo_empty ? 16'($urandom) : fq[0];
    #1;
    obs_rd_en = fifo_rd_en;
    obs_valid = out_valid;
    obs_last  = out_last;
    obs_done  = pkt_done;
    obs_data  = out_data;

    e_valid = (bq.size() != 0);
    e_rd_en = !rst && (fq.size() != 0) && (bq.size() < 2);
    e_last  = e_valid && (m_idx == PKT_LEN - 1);

    n_cmp++;
    if (obs_rd_en !== e_rd_en) begin
      n_err++;
      $display("FAIL rd_en @%0t: got %b want %b", $time, obs_rd_en, e_rd_en);
    end
    n_cmp++;
    if (obs_valid !== e_valid) begin
      n_err++;
      $display("FAIL out_valid @%0t: got %b want %b", $time, obs_valid, e_valid);
    end
    n_cmp++;
    if (obs_last !== e_last) begin
      n_err++;
      $display("FAIL out_last @%0t: got %b want %b", $time, obs_last, e_last);
    end
    n_cmp++;
    if (obs_done !== m_done) begin
      n_err++;
      $display("FAIL pkt_done @%0t: got %b want %b", $time, obs_done, m_done);
    end
    if (e_valid) begin
      n_cmp++;
      if (obs_data !== bq[0]) begin
        n_err++;
        $display("FAIL out_data @%0t: got %h want %h", $time, obs_data, bq[0]);
      end
    end
`ifdef RD_STREAMER_STATS_EN
    n_cmp++;
    if (words_sent !== 16'(m_ws) || stall_cycles !== 16'(m_sc)) begin
      n_err++;
      $display("FAIL stats @%0t: got %0d/%0d want %0d/%0d", $time,
               words_sent, stall_cycles, m_ws, m_sc);
    end
`endif

    if (!rst && obs_valid === 1'b1 && rdy) begin
      acc.push_back(obs_data);
      if (obs_last === 1'b1) lasts.push_back(obs_data);
    end
    if (obs_done === 1'b1) n_done++;

    if (rst) begin
      bq.delete();
      m_idx  = 0;
      m_done = 0;
      m_ws   = 0;
      m_sc   = 0;
    end else begin
      acc_now = e_valid && rdy;
      m_done  = acc_now && (m_idx == PKT_LEN - 1);
      if (e_valid && !rdy && m_sc < 65535) m_sc++;
      if (acc_now) begin
        void'(bq.pop_front());
        m_idx = (m_idx == PKT_LEN - 1) ? 0 : m_idx + 1;
        if (m_ws < 65535) m_ws++;
      end
      if (e_rd_en) bq.push_back(fq[0]);
    end
    if (obs_rd_en === 1'b1 && fq.size() != 0) void'(fq.pop_front());
  endtask

  task automatic clear_obs();
    acc.delete();
    lasts.delete();
    n_done = 0;
  endtask

  task automatic test_reset();
    fq = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1);
      n_cmp++;
      if (obs_rd_en !== 1'b0 || obs_valid !== 1'b0 || obs_last !== 1'b0 ||
          obs_done !== 1'b0 || obs_data !== 16'h0000) begin
        n_err++;
        $display("FAIL reset_state: rd_en=%b valid=%b last=%b done=%b data=%h, want all 0",
                 obs_rd_en, obs_valid, obs_last, obs_done, obs_data);
      end
    end
    fq.delete();
  endtask

  task automatic test_streaming();
    bit ok;
    clear_obs();
    for (int i = 1; i <= 16; i++) fq.push_back(16'(i));
    repeat (17) cycle(1'b0, 1'b1);
    ok = (acc.size() == 16);
    for (int i = 0; i < acc.size() && ok; i++) ok = (acc[i] == 16'(i + 1));
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL stream_order: got %0d words, want 16 words 0x0001..0x0010 in 17 cycles",
               acc.size());
    end
    cycle(1'b0, 1'b1);
    n_cmp++;
    if (lasts.size() != 2 || lasts[0] != 16'h0008 || lasts[1] != 16'h0010) begin
      n_err++;
      $display("FAIL stream_last: got %0d flagged words, want 0x0008 and 0x0010", lasts.size());
    end
    n_cmp++;
    if (n_done != 2) begin
      n_err++;
      $display("FAIL stream_pkt_done: got %0d pulses want 2", n_done);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_obs();
    for (int i = 1; i <= 5; i++) fq.push_back(16'(i));
    repeat (3) cycle(1'b0, 1'b0);
    n_cmp++;
    if (obs_rd_en !== 1'b0 || obs_valid !== 1'b1 || obs_data !== 16'h0001) begin
      n_err++;
      $display("FAIL bp_full: rd_en=%b valid=%b data=%h, want 0/1/0001",
               obs_rd_en, obs_valid, obs_data);
    end
    cycle(1'b0, 1'b0);
    n_cmp++;
    if (obs_data !== 16'h0001) begin
      n_err++;
      $display("FAIL bp_hold: got %h want 0001", obs_data);
    end
    repeat (8) cycle(1'b0, 1'b1);
    ok = (acc.size() == 5);
    for (int i = 0; i < acc.size() && ok; i++) ok = (acc[i] == 16'(i + 1));
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL bp_release: got %0d words, want 0x0001..0x0005 once each", acc.size());
    end
  endtask

  task automatic test_underrun();
    cycle(1'b1, 1'b0);
    clear_obs();
    fq = '{16'h0041, 16'h0042, 16'h0043};
    repeat (4) cycle(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1);
      n_cmp++;
      if (obs_valid !== 1'b0) begin
        n_err++;
        $display("FAIL underrun_gap: cycle %0d valid=%b want 0", i, obs_valid);
      end
    end
    for (int i = 1; i <= 5; i++) fq.push_back(16'h0050 + 16'(i));
    repeat (7) cycle(1'b0, 1'b1);
    n_cmp++;
    if (acc.size() != 8 || lasts.size() != 1 || lasts[0] != 16'h0055 || n_done != 1) begin
      n_err++;
      $display("FAIL underrun_resume: words=%0d lasts=%0d done=%0d, want 8/1 on 0055/1",
               acc.size(), lasts.size(), n_done);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0);
    clear_obs();
    for (int i = 0; i < 5; i++) fq.push_back(16'h0060 + 16'(i));
    repeat (6) cycle(1'b0, 1'b1);
    for (int i = 5; i < 9; i++) fq.push_back(16'h0060 + 16'(i));
    repeat (3) cycle(1'b0, 1'b0);
    n_cmp++;
    if (obs_rd_en !== 1'b0 || acc.size() != 5) begin
      n_err++;
      $display("FAIL midrst_setup: rd_en=%b words=%0d, want 0 and 5", obs_rd_en, acc.size());
    end
    cycle(1'b1, 1'b0);
    n_cmp++;
    if (obs_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_no_pop: got %b want 0", obs_rd_en);
    end
    clear_obs();
    cycle(1'b0, 1'b1);
    n_cmp++;
    if (obs_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_valid: got %b want 0", obs_valid);
    end
    for (int i = 9; i < 15; i++) fq.push_back(16'h0060 + 16'(i));
    repeat (9) cycle(1'b0, 1'b1);
    n_cmp++;
    if (acc.size() != 8 || acc[0] != 16'h0067 || lasts.size() != 1 || lasts[0] != 16'h006E) begin
      n_err++;
      $display("FAIL midrst_resume: words=%0d lasts=%0d, want 8 from 0067 with last on 006E",
               acc.size(), lasts.size());
    end
  endtask

  task automatic test_random();
    int pushed;
    cycle(1'b1, 1'b0);
    clear_obs();
    pushed = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0 && fq.size() < 6) begin
        fq.push_back(16'($urandom));
        pushed++;
      end
      cycle(1'b0, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
    n_cmp++;
    if (acc.size() != pushed) begin
      n_err++;
      $display("FAIL random_count: got %0d accepted want %0d", acc.size(), pushed);
    end
  endtask

`ifdef RD_STREAMER_STATS_EN
  task automatic test_stats();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    n_cmp++;
    if (words_sent !== 16'd0 || stall_cycles !== 16'd0) begin
      n_err++;
      $display("FAIL stats_reset: got %0d/%0d want 0/0", words_sent, stall_cycles);
    end
    clear_obs();
    for (int i = 0; i < 10; i++) fq.push_back(16'h0100 + 16'(i));
    cycle(1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0);
    for (int i = 0; i < 20 && acc.size() < 10; i++) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    n_cmp++;
    if (words_sent !== 16'd10 || stall_cycles !== 16'd4) begin
      n_err++;
      $display("FAIL stats_count: got %0d/%0d want 10/4", words_sent, stall_cycles);
    end
  endtask
`endif

  initial begin
    rd_rst       = 1'b1;
    out_ready    = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;
    m_idx  = 0;
    m_done = 0;
    m_ws   = 0;
    m_sc   = 0;
    n_done = 0;
    repeat (2) @(posedge rd_clk);

    test_reset();
    test_streaming();
    test_backpressure();
    test_underrun();
    test_reset_mid();
    test_random();
`ifdef RD_STREAMER_STATS_EN
    test_stats();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
